// File: rtl/video_pkg.sv
// Shared definitions for the video stream source: dimension limits, pattern
// and FSM encodings, the latched configuration record, the colour-bar table
// and the CRC-32 constants used by vsrc_crc32.
package video_pkg;

    // Default frame limits. Both must stay within the 12-bit cfg ports.
    localparam int VSRC_MAX_WIDTH  = 1280;
    localparam int VSRC_MAX_HEIGHT = 2048;

    // CRC-32 (IEEE): polynomial 0x04C11DB7 processed bit-reversed.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_LGAP   = 3'd3,
        ST_FGAP   = 3'd4
    } state_e;

    // Configuration captured once per frame in LOAD.
    typedef struct packed {
        logic [11:0] width;
        logic [11:0] height;
        pattern_e    pattern;
        logic [31:0] color;
        logic [7:0]  line_gap;
        logic [15:0] frame_gap;
    } cfg_t;

    // Colour bars, index 0 (leftmost) to 7: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [7:0][31:0] BAR_COLOR = {
        32'h0000_0000,  // 7 black
        32'h0000_00FF,  // 6 blue
        32'h00FF_0000,  // 5 red
        32'h00FF_00FF,  // 4 magenta
        32'h0000_FF00,  // 3 green
        32'h0000_FFFF,  // 2 cyan
        32'h00FF_FF00,  // 1 yellow
        32'h00FF_FFFF   // 0 white
    };

    // Saturate a requested dimension at the build-time maximum.
    function automatic logic [11:0] clamp_dim(input logic [11:0] value,
                                              input logic [11:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/vsrc_crc32.sv
// Per-frame CRC-32 accumulator. Each update folds one 32-bit pixel in as four
// bytes, least-significant byte first, using the reflected IEEE polynomial.
// result is the finalised CRC including the word being updated this cycle,
// so the caller can capture it on the same edge as the last handshake.
module vsrc_crc32
    import video_pkg::*;
(
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        update,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // One byte of the bit-serial reflected CRC, unrolled into logic.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data_byte);
        logic [31:0] c;
        c = crc ^ {24'd0, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Next accumulator value: fold all four byte lanes on an update.
    always_comb begin
        // NOTE: default assignment first so no path leaves crc_d unassigned (no latch).
        crc_d = crc_q;
        if (update) begin
            for (int lane = 0; lane < 4; lane++) begin
                crc_d = crc32_byte(crc_d, data[lane*8 +: 8]);
            end
        end
    end

    // Accumulator register, re-seeded at reset and at the start of each frame.
    always_ff @(posedge m_axis_vid_aclk) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (!aresetn || clear) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign result = crc_d ^ CRC32_XOROUT;

endmodule

// File: rtl/video_stream_source.sv
// AXI4-Stream video test-pattern source. Generates one frame per enable
// (solid, ramp, colour bars or checker), with programmable idle gaps between
// lines and after each frame. Configuration is captured in LOAD and held for
// the whole frame.
// Optional build macro VSRC_CRC_EN: adds a per-frame CRC-32 of all pixel
// bytes on frame_crc; without it frame_crc is constant zero.
module video_stream_source
    import video_pkg::*;
#(
    parameter int MAX_WIDTH  = VSRC_MAX_WIDTH,
    parameter int MAX_HEIGHT = VSRC_MAX_HEIGHT
) (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    input  logic        enable,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic [1:0]  cfg_pattern,
    input  logic [31:0] cfg_color,
    input  logic [7:0]  cfg_line_gap,
    input  logic [15:0] cfg_frame_gap,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        cfg_err,
    output logic [31:0] frame_crc
);

    state_e      state_q;
    state_e      state_d;
    cfg_t        cfg_q;
    cfg_t        cfg_load;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [15:0] gap_q;
    logic [11:0] bar_cnt_q;
    logic [2:0]  bar_idx_q;
    logic [15:0] frame_count_q;
    logic        cfg_err_q;

    logic        cfg_ok;
    logic        hs;
    logic        last_x;
    logic        last_y;
    logic        frame_end;
    logic [11:0] bar_w;

    assign cfg_ok    = (cfg_width != 12'd0) && (cfg_height != 12'd0);
    assign hs        = (state_q == ST_STREAM) && m_axis_vid_tready;
    assign last_x    = (x_q == cfg_q.width - 12'd1);
    assign last_y    = (y_q == cfg_q.height - 12'd1);
    assign frame_end = hs && last_x && last_y;
    // Bar width is width/8, but never zero for lines narrower than 8 pixels.
    assign bar_w     = (cfg_q.width[11:3] == 9'd0) ? 12'd1 : {3'd0, cfg_q.width[11:3]};

    // Configuration snapshot taken from the cfg_* ports, with clamping.
    always_comb begin
        cfg_load           = '0;
        cfg_load.width     = clamp_dim(cfg_width,  12'(MAX_WIDTH));
        cfg_load.height    = clamp_dim(cfg_height, 12'(MAX_HEIGHT));
        cfg_load.pattern   = pattern_e'(cfg_pattern);
        cfg_load.color     = cfg_color;
        cfg_load.line_gap  = cfg_line_gap;
        cfg_load.frame_gap = cfg_frame_gap;
    end

    // FSM state register.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. FGAP's first cycle is the frame_done cycle; the
    // programmed frame gap follows it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && cfg_ok) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (hs && last_x) begin
                    if (last_y) begin
                        state_d = ST_FGAP;
                    end else if (cfg_q.line_gap != 8'd0) begin
                        state_d = ST_LGAP;
                    end
                end
            end
            ST_LGAP: begin
                if (gap_q == {8'd0, cfg_q.line_gap} - 16'd1) begin
                    state_d = ST_STREAM;
                end
            end
            ST_FGAP: begin
                if (gap_q == cfg_q.frame_gap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: config capture, pixel/line/bar/gap counters, frame counter.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            cfg_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            gap_q         <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            frame_count_q <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cfg_err_q <= enable && !cfg_ok;
                end
                ST_LOAD: begin
                    cfg_q     <= cfg_load;
                    x_q       <= '0;
                    y_q       <= '0;
                    gap_q     <= '0;
                    bar_cnt_q <= '0;
                    bar_idx_q <= '0;
                end
                ST_STREAM: begin
                    if (hs) begin
                        if (last_x) begin
                            x_q       <= '0;
                            bar_cnt_q <= '0;
                            bar_idx_q <= '0;
                            gap_q     <= '0;
                            if (last_y) begin
                                frame_count_q <= frame_count_q + 16'd1;
                            end else begin
                                y_q <= y_q + 12'd1;
                            end
                        end else begin
                            x_q <= x_q + 12'd1;
                            if (bar_cnt_q == bar_w - 12'd1) begin
                                bar_cnt_q <= '0;
                                if (bar_idx_q != 3'd7) begin
                                    bar_idx_q <= bar_idx_q + 3'd1;
                                end
                            end else begin
                                bar_cnt_q <= bar_cnt_q + 12'd1;
                            end
                        end
                    end
                end
                ST_LGAP, ST_FGAP: begin
                    gap_q <= gap_q + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state; the pixel value depends only on
    // counters that move on a handshake, so it holds steady while stalled.
    always_comb begin
        m_axis_vid_tvalid = 1'b0;
        m_axis_vid_tlast  = 1'b0;
        m_axis_vid_tuser  = 1'b0;
        m_axis_vid_tdata  = '0;
        busy              = (state_q != ST_IDLE);
        frame_done        = (state_q == ST_FGAP) && (gap_q == 16'd0);
        if (state_q == ST_STREAM) begin
            m_axis_vid_tvalid = 1'b1;
            m_axis_vid_tlast  = last_x;
            m_axis_vid_tuser  = (x_q == 12'd0) && (y_q == 12'd0);
            case (cfg_q.pattern)
                PAT_SOLID:   m_axis_vid_tdata = cfg_q.color;
                PAT_RAMP:    m_axis_vid_tdata = {8'h00, x_q[7:0], x_q[7:0], x_q[7:0]};
                PAT_BARS:    m_axis_vid_tdata = BAR_COLOR[bar_idx_q];
                PAT_CHECKER: m_axis_vid_tdata = (x_q[4] ^ y_q[4] ^ frame_count_q[0])
                                                ? cfg_q.color : 32'd0;
                default:     m_axis_vid_tdata = '0;
            endcase
        end
    end

    assign frame_count = frame_count_q;
    assign cfg_err     = cfg_err_q;

`ifdef VSRC_CRC_EN
    logic [31:0] crc_result;
    logic [31:0] frame_crc_q;
    logic        crc_clear;

    assign crc_clear = (state_q == ST_LOAD);

    vsrc_crc32 u_crc (
        .m_axis_vid_aclk (m_axis_vid_aclk),
        .aresetn         (aresetn),
        .clear           (crc_clear),
        .update          (hs),
        .data            (m_axis_vid_tdata),
        .result          (crc_result)
    );

    // Capture the finished CRC on the final handshake; visible with frame_done.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            frame_crc_q <= '0;
        end else if (frame_end) begin
            frame_crc_q <= crc_result;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign frame_crc        = '0;
`endif

endmodule

// File: tb/tb_video_stream_source.sv
// Scoreboard bench for video_stream_source: expected beats are queued when a
// frame is launched, and a monitor pops and compares on every handshake.
module tb_video_stream_source;

    localparam int MAX_W = 1280;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        enable;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic [1:0]  cfg_pattern;
    logic [31:0] cfg_color;
    logic [7:0]  cfg_line_gap;
    logic [15:0] cfg_frame_gap;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        cfg_err;
    logic [31:0] frame_crc;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    fd_count = 0;
    int    exp_fc = 0;

    always #5 clk = ~clk;

    video_stream_source dut (
        .m_axis_vid_aclk   (clk),
        .aresetn           (aresetn),
        .m_axis_vid_tdata  (tdata),
        .m_axis_vid_tvalid (tvalid),
        .m_axis_vid_tready (tready),
        .m_axis_vid_tlast  (tlast),
        .m_axis_vid_tuser  (tuser),
        .enable            (enable),
        .cfg_width         (cfg_width),
        .cfg_height        (cfg_height),
        .cfg_pattern       (cfg_pattern),
        .cfg_color         (cfg_color),
        .cfg_line_gap      (cfg_line_gap),
        .cfg_frame_gap     (cfg_frame_gap),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .cfg_err           (cfg_err),
        .frame_crc         (frame_crc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bar_color(input int idx);
        case (idx)
            0:       return 32'h00FFFFFF;
            1:       return 32'h00FFFF00;
            2:       return 32'h0000FFFF;
            3:       return 32'h0000FF00;
            4:       return 32'h00FF00FF;
            5:       return 32'h00FF0000;
            6:       return 32'h000000FF;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] exp_pixel(input int pat, input logic [31:0] color,
                                              input int w, input int x, input int y,
                                              input int fc);
        logic [7:0] xb;
        int bw;
        int idx;
        xb = 8'(x);
        case (pat)
            0: return color;
            1: return {8'h00, xb, xb, xb};
            2: begin
                bw  = (w / 8 == 0) ? 1 : w / 8;
                idx = x / bw;
                if (idx > 7) idx = 7;
                return bar_color(idx);
            end
            default: return ((((x >> 4) ^ (y >> 4) ^ fc) & 1) != 0) ? color : 32'd0;
        endcase
    endfunction

    // Monitor: compare each handshake against the scoreboard, and check that a
    // stalled beat stays presented and unchanged.
    logic        stall_pending = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic        held_user;

    always @(negedge clk) begin
        beat_t exp_b;
        if (aresetn) begin
            if (frame_done) fd_count++;
            if (stall_pending) begin
                check("stall_valid", {31'd0, tvalid}, 32'd1);
                check("stall_data", tdata, held_data);
                check("stall_ctrl", {30'd0, tlast, tuser}, {30'd0, held_last, held_user});
            end
            if (tvalid && tready) begin
                check("beat_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("beat_data", tdata, exp_b.data);
                    check("beat_last", {31'd0, tlast}, {31'd0, exp_b.last});
                    check("beat_user", {31'd0, tuser}, {31'd0, exp_b.user});
                end
            end
            stall_pending = tvalid && !tready;
            held_data     = tdata;
            held_last     = tlast;
            held_user     = tuser;
        end else begin
            stall_pending = 1'b0;
        end
    end

    // Launch one frame, queue its expected beats, and measure the gaps.
    task automatic run_frame(input int w, input int h, input int pat,
                             input logic [31:0] color, input int lg, input int fg,
                             input bit toggle);
        int  ew;
        int  fd_before;
        int  lgap;
        int  fgap;
        int  budget;
        bit  seen_fd;
        bit  done;
        ew = (w > MAX_W) ? MAX_W : w;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < ew; x++) begin
                sb.push_back('{exp_pixel(pat, color, ew, x, y, exp_fc),
                               (x == ew - 1), (x == 0 && y == 0)});
            end
        end
        cfg_width     = 12'(w);
        cfg_height    = 12'(h);
        cfg_pattern   = 2'(pat);
        cfg_color     = color;
        cfg_line_gap  = 8'(lg);
        cfg_frame_gap = 16'(fg);
        tready        = 1'b1;
        fd_before     = fd_count;
        enable        = 1'b1;
        tick();
        enable = 1'b0;
        check("load_tvalid", {31'd0, tvalid}, 32'd0);
        check("load_busy", {31'd0, busy}, 32'd1);
        tick();
        check("first_tvalid", {31'd0, tvalid}, 32'd1);
        check("first_tuser", {31'd0, tuser}, 32'd1);
        // Disturb the inputs; the frame in flight must not notice.
        cfg_color   = ~color;
        cfg_width   = 12'd7;
        cfg_pattern = 2'(pat + 1);
        seen_fd = 1'b0;
        done    = 1'b0;
        lgap    = 0;
        fgap    = 0;
        budget  = 3 * ew * h + lg * h + fg + 64;
        for (int c = 0; c < budget && !done; c++) begin
            if (frame_done) seen_fd = 1'b1;
            else if (seen_fd) begin
                if (busy) fgap++;
                else done = 1'b1;
            end else if (busy && !tvalid) lgap++;
            if (!done) begin
                if (toggle) tready = ~tready;
                tick();
            end
        end
        tready = 1'b1;
        check("frame_timeout", {31'd0, done}, 32'd1);
        exp_fc = (exp_fc + 1) & 16'hFFFF;
        check("frame_count", {16'd0, frame_count}, 32'(exp_fc));
        check("frame_done_pulses", 32'(fd_count - fd_before), 32'd1);
        check("line_gap_cycles", 32'(lgap), 32'(lg * (h - 1)));
        check("frame_gap_cycles", 32'(fgap), 32'(fg));
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tv_seen;
        aresetn       = 1'b0;
        tready        = 1'b1;
        enable        = 1'b0;
        cfg_width     = 12'd4;
        cfg_height    = 12'd2;
        cfg_pattern   = 2'd0;
        cfg_color     = 32'd0;
        cfg_line_gap  = 8'd0;
        cfg_frame_gap = 16'd0;
        tick();
        tick();
        tick();
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_ctrl", {28'd0, tlast, tuser, busy, frame_done}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_frame_crc", frame_crc, 32'd0);
        aresetn = 1'b1;
        tick();

        // 4x2 solid colour, no gaps.
        run_frame(4, 2, 0, 32'h00123456, 0, 0, 1'b0);
        // 16-pixel ramp with tready toggling every cycle.
        run_frame(16, 1, 1, 32'd0, 0, 0, 1'b1);
        // Colour bars: two pixels per bar, then one pixel per bar.
        run_frame(16, 1, 2, 32'd0, 0, 0, 1'b0);
        run_frame(5, 1, 2, 32'd0, 0, 0, 1'b0);
        // Line and frame gaps.
        run_frame(2, 2, 0, 32'h00ABCDEF, 3, 10, 1'b0);
        // Checker across x[4]/y[4] with odd frame parity, stalling sink.
        run_frame(20, 17, 3, 32'h00C0FFEE, 1, 2, 1'b1);
        // Oversized width clamps to the maximum line length.
        run_frame(4095, 1, 1, 32'd0, 0, 0, 1'b0);

        // Zero width: flagged, never streams.
        cfg_width  = 12'd0;
        cfg_height = 12'd4;
        enable     = 1'b1;
        tv_seen    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tvalid) tv_seen = 1'b1;
        end
        check("cfg_err_set", {31'd0, cfg_err}, 32'd1);
        check("cfg_err_no_tvalid", {31'd0, tv_seen}, 32'd0);
        check("cfg_err_idle", {31'd0, busy}, 32'd0);
        enable = 1'b0;
        tick();

        // Reset while beat 5 of a 4x4 ramp frame is presented.
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{{8'h00, 8'(k % 4), 8'(k % 4), 8'(k % 4)}, (k % 4 == 3), (k == 0)});
        end
        cfg_width   = 12'd4;
        cfg_height  = 12'd4;
        cfg_pattern = 2'd1;
        enable      = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("beat5_data", tdata, 32'h00010101);
        tready  = 1'b0;
        aresetn = 1'b0;
        tick();
        check("abort_tvalid", {31'd0, tvalid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_frame_count", {16'd0, frame_count}, 32'd0);
        check("abort_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("abort_sb_drained", 32'(sb.size()), 32'd0);
        aresetn = 1'b1;
        tready  = 1'b1;
        exp_fc  = 0;
        tick();

        // Single black pixel: restarts with tuser after the abort; CRC of 4 zero bytes.
        run_frame(1, 1, 0, 32'd0, 0, 0, 1'b0);
`ifdef VSRC_CRC_EN
        check("frame_crc", frame_crc, 32'h2144DF1C);
`else
        check("frame_crc", frame_crc, 32'd0);
`endif
        check("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
